// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types and constants for the ID/EX stage (package riscv_pipe_pkg).
package riscv_pipe_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned REGW_DEF  = 5;
   localparam int unsigned ALUCTRL_W = 3;
   localparam int unsigned F3_W      = 3;
   localparam int unsigned RSRC_W    = 2;
   localparam int unsigned CNT_W     = 32;

   localparam logic [RSRC_W-1:0] RESULT_ALU = 2'b00;
   localparam logic [RSRC_W-1:0] RESULT_MEM = 2'b01;
   localparam logic [RSRC_W-1:0] RESULT_PC4 = 2'b10;

   localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
   localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
   localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
   localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
   localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic                 mem_write;
      logic                 jump;
      logic                 branch;
      logic                 alu_src;
      logic [RSRC_W-1:0]    result_src;
      logic [ALUCTRL_W-1:0] alu_control;
      logic [F3_W-1:0]      funct3;
   } ex_ctrl_t;

   // Saturating increment used by the performance counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: D-side inputs, E-side registered outputs, branch flags, counters.
interface id_ex_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned REGW = 5
);
   logic            StallE, FlushE, ValidD;
   logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]      ResultSrcD;
   logic [2:0]      ALUControlD, funct3D;
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [REGW-1:0] Rs1D, Rs2D, RdD;
   logic            ZeroE, NegE, CarryE, OverflowE;

   logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE, funct3E;
   logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [REGW-1:0] Rs1E, Rs2E, RdE;
   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic [31:0]     BubbleCnt, TakenCnt;

   modport slave (
      input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
             ResultSrcD, ALUControlD, funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
             Rs1D, Rs2D, RdD, ZeroE, NegE, CarryE, OverflowE,
      output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
             ALUControlE, funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E,
             RdE, PCSrcE, PCTargetE, BubbleCnt, TakenCnt
   );

   modport master (
      output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
             ResultSrcD, ALUControlD, funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
             Rs1D, Rs2D, RdD, ZeroE, NegE, CarryE, OverflowE,
      input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
             ALUControlE, funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E,
             RdE, PCSrcE, PCTargetE, BubbleCnt, TakenCnt
   );
endinterface

// File: rtl/id_ex_stage_branch_resolve.sv
// Branch condition evaluation from E-stage ALU flags (A-B); drives the fetch redirect.
module branch_resolve
   import riscv_pipe_pkg::*;
(
   input  logic            valid,
   input  logic            jump,
   input  logic            branch,
   input  logic [F3_W-1:0] funct3,
   input  logic            zero,
   input  logic            neg,
   input  logic            carry,
   input  logic            overflow,
   output logic            pc_src
);
   logic take;

   // carry=1 means A>=B unsigned (no borrow); neg^overflow is the signed A<B.
   always_comb begin
      take = 1'b0;
      unique case (funct3)
         F3_BEQ:  take = zero;
         F3_BNE:  take = ~zero;
         F3_BLT:  take = neg ^ overflow;
         F3_BGE:  take = ~(neg ^ overflow);
         F3_BLTU: take = ~carry;
         F3_BGEU: take = carry;
         default: take = 1'b0;
      endcase
   end

   assign pc_src = valid & (jump | (branch & take));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, branch resolution and PC target.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned REGW = REGW_DEF
) (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);
   ex_ctrl_t        ctrl_d, ctrl_q;
   logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
   logic [REGW-1:0] rs1_q, rs2_q, rd_q;

   always_comb begin
      ctrl_d = '{valid:       bus.ValidD,
                 reg_write:   bus.RegWriteD,
                 mem_write:   bus.MemWriteD,
                 jump:        bus.JumpD,
                 branch:      bus.BranchD,
                 alu_src:     bus.ALUSrcD,
                 result_src:  bus.ResultSrcD,
                 alu_control: bus.ALUControlD,
                 funct3:      bus.funct3D};
   end

   // Flush beats stall; a flushed slot is an all-zero bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.FlushE) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         pc_q   <= '0;
         pc4_q  <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
      end else if (!bus.StallE) begin
         ctrl_q <= ctrl_d;
         rd1_q  <= bus.RD1D;
         rd2_q  <= bus.RD2D;
         imm_q  <= bus.ImmExtD;
         pc_q   <= bus.PCD;
         pc4_q  <= bus.PCPlus4D;
         rs1_q  <= bus.Rs1D;
         rs2_q  <= bus.Rs2D;
         rd_q   <= bus.RdD;
      end
   end

   assign bus.ValidE      = ctrl_q.valid;
   assign bus.RegWriteE   = ctrl_q.reg_write;
   assign bus.MemWriteE   = ctrl_q.mem_write;
   assign bus.JumpE       = ctrl_q.jump;
   assign bus.BranchE     = ctrl_q.branch;
   assign bus.ALUSrcE     = ctrl_q.alu_src;
   assign bus.ResultSrcE  = ctrl_q.result_src;
   assign bus.ALUControlE = ctrl_q.alu_control;
   assign bus.funct3E     = ctrl_q.funct3;
   assign bus.RD1E        = rd1_q;
   assign bus.RD2E        = rd2_q;
   assign bus.ImmExtE     = imm_q;
   assign bus.PCE         = pc_q;
   assign bus.PCPlus4E    = pc4_q;
   assign bus.Rs1E        = rs1_q;
   assign bus.Rs2E        = rs2_q;
   assign bus.RdE         = rd_q;
   assign bus.PCTargetE   = pc_q + imm_q;

   branch_resolve u_branch_resolve (
      .valid    (ctrl_q.valid),
      .jump     (ctrl_q.jump),
      .branch   (ctrl_q.branch),
      .funct3   (ctrl_q.funct3),
      .zero     (bus.ZeroE),
      .neg      (bus.NegE),
      .carry    (bus.CarryE),
      .overflow (bus.OverflowE),
      .pc_src   (bus.PCSrcE)
   );

`ifdef ID_EX_PERF_CNT_EN
   logic             next_valid;
   logic [CNT_W-1:0] bubble_q, taken_q;

   assign next_valid = bus.FlushE ? 1'b0 : (bus.StallE ? ctrl_q.valid : bus.ValidD);

   // Saturating event counters sampled on the same edge as the pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_q <= '0;
         taken_q  <= '0;
      end else begin
         if (!next_valid)
            bubble_q <= sat_inc(bubble_q);
         if (bus.PCSrcE && !bus.StallE)
            taken_q <= sat_inc(taken_q);
      end
   end

   assign bus.BubbleCnt = bubble_q;
   assign bus.TakenCnt  = taken_q;
`else
   assign bus.BubbleCnt = '0;
   assign bus.TakenCnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic against a reference model.
module tb_id_ex_stage;
   logic clk, reset;
   int   checks, failures;

   id_ex_stage_if #(.XLEN(32), .REGW(5)) bus();
   id_ex_stage #(.XLEN(32), .REGW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        valid, rw, mw, jump, branch, alusrc;
      bit [1:0]  rsrc;
      bit [2:0]  aluc, f3;
      bit [31:0] rd1, rd2, imm, pc, pc4;
      bit [4:0]  rs1, rs2, rd;
   } st_t;

   st_t       d, m, zero_st;
   bit [31:0] op_a, op_b;
   bit [31:0] m_bub, m_taken;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Branch outcome from the architectural comparison of the ALU operands.
   function automatic bit cond(input bit [2:0] f, input bit [31:0] a, input bit [31:0] b);
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_pcsrc();
      return m.valid && (m.jump || (m.branch && cond(m.f3, op_a, op_b)));
   endfunction

   // Present the flags an ALU computing a-b would produce.
   task automatic set_ops(input bit [31:0] a, input bit [31:0] b);
      bit [32:0] diff;
      op_a = a;
      op_b = b;
      diff = {1'b0, a} - {1'b0, b};
      bus.ZeroE     = (diff[31:0] == 32'd0);
      bus.NegE      = diff[31];
      bus.CarryE    = ~diff[32];
      bus.OverflowE = (a[31] != b[31]) && (diff[31] != a[31]);
   endtask

   task automatic apply_d(input st_t s);
      bus.ValidD = s.valid;  bus.RegWriteD = s.rw;  bus.MemWriteD = s.mw;
      bus.JumpD = s.jump;    bus.BranchD = s.branch; bus.ALUSrcD = s.alusrc;
      bus.ResultSrcD = s.rsrc; bus.ALUControlD = s.aluc; bus.funct3D = s.f3;
      bus.RD1D = s.rd1; bus.RD2D = s.rd2; bus.ImmExtD = s.imm;
      bus.PCD = s.pc;   bus.PCPlus4D = s.pc4;
      bus.Rs1D = s.rs1; bus.Rs2D = s.rs2; bus.RdD = s.rd;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ValidE"},    64'(bus.ValidE),      64'(m.valid));
      chk({tag, ".RegWriteE"}, 64'(bus.RegWriteE),   64'(m.rw));
      chk({tag, ".MemWriteE"}, 64'(bus.MemWriteE),   64'(m.mw));
      chk({tag, ".JumpE"},     64'(bus.JumpE),       64'(m.jump));
      chk({tag, ".BranchE"},   64'(bus.BranchE),     64'(m.branch));
      chk({tag, ".ALUSrcE"},   64'(bus.ALUSrcE),     64'(m.alusrc));
      chk({tag, ".ResultSrcE"},64'(bus.ResultSrcE),  64'(m.rsrc));
      chk({tag, ".ALUCtrlE"},  64'(bus.ALUControlE), 64'(m.aluc));
      chk({tag, ".funct3E"},   64'(bus.funct3E),     64'(m.f3));
      chk({tag, ".RD1E"},      64'(bus.RD1E),        64'(m.rd1));
      chk({tag, ".RD2E"},      64'(bus.RD2E),        64'(m.rd2));
      chk({tag, ".ImmExtE"},   64'(bus.ImmExtE),     64'(m.imm));
      chk({tag, ".PCE"},       64'(bus.PCE),         64'(m.pc));
      chk({tag, ".PCPlus4E"},  64'(bus.PCPlus4E),    64'(m.pc4));
      chk({tag, ".Rs1E"},      64'(bus.Rs1E),        64'(m.rs1));
      chk({tag, ".Rs2E"},      64'(bus.Rs2E),        64'(m.rs2));
      chk({tag, ".RdE"},       64'(bus.RdE),         64'(m.rd));
      chk({tag, ".PCTargetE"}, 64'(bus.PCTargetE),   64'((64'(m.pc) + 64'(m.imm)) % 64'h1_0000_0000));
      chk({tag, ".PCSrcE"},    64'(bus.PCSrcE),      64'(model_pcsrc()));
      chk({tag, ".BubbleCnt"}, 64'(bus.BubbleCnt),   64'(m_bub));
      chk({tag, ".TakenCnt"},  64'(bus.TakenCnt),    64'(m_taken));
   endtask

   // Advance one clock with the currently driven inputs, update the model, then check.
   task automatic step(input string tag);
      bit taken_now, nv;
      taken_now = model_pcsrc() && !bus.StallE;
      nv = bus.FlushE ? 1'b0 : (bus.StallE ? m.valid : d.valid);
      if (bus.FlushE)      m = zero_st;
      else if (!bus.StallE) m = d;
`ifdef ID_EX_PERF_CNT_EN
      if (!nv && m_bub != 32'hFFFF_FFFF) m_bub++;
      if (taken_now && m_taken != 32'hFFFF_FFFF) m_taken++;
`else
      if (taken_now || nv) begin end
`endif
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m = zero_st;
      m_bub = 0;
      m_taken = 0;
      @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      zero_st = '{default: 0};
      d = zero_st;
      m = zero_st;
      m_bub = 0;
      m_taken = 0;
      reset = 1'b1;
      bus.StallE = 1'b0;
      bus.FlushE = 1'b0;
      apply_d(d);
      set_ops(32'd0, 32'd1);
      #2;
      do_reset();

      // Basic load, one-cycle latency
      d = zero_st; d.valid = 1; d.rd = 7; d.rd1 = 32'h10; d.imm = 32'h8; d.pc = 32'h100;
      apply_d(d);
      step("load");
      chk("load.RdE", 64'(bus.RdE), 64'd7);
      chk("load.target", 64'(bus.PCTargetE), 64'h108);

      // Stall holds, flush beats stall
      d.rd = 3; apply_d(d); step("ld3");
      d.rd = 9; apply_d(d); bus.StallE = 1'b1; step("stall");
      chk("stall.RdE", 64'(bus.RdE), 64'd3);
      bus.FlushE = 1'b1; step("stallflush");
      chk("stallflush.ValidE", 64'(bus.ValidE), 64'd0);
      chk("stallflush.RdE", 64'(bus.RdE), 64'd0);
      bus.StallE = 1'b0; bus.FlushE = 1'b0;

      // Branch conditions
      d = zero_st; d.valid = 1; d.branch = 1; d.f3 = 3'b001;
      set_ops(32'd1, 32'd2); apply_d(d); step("bne");
      chk("bne.PCSrcE", 64'(bus.PCSrcE), 64'd1);
      d.f3 = 3'b110; set_ops(32'd5, 32'd3); apply_d(d); step("bltu");
      chk("bltu.PCSrcE", 64'(bus.PCSrcE), 64'd0);
      d.f3 = 3'b100; set_ops(32'h7FFF_FFFF, 32'hFFFF_FFFF); apply_d(d); step("blt");
      chk("blt.NegOvf", {62'd0, bus.NegE, bus.OverflowE}, 64'd3);
      chk("blt.PCSrcE", 64'(bus.PCSrcE), 64'd0);
      d.f3 = 3'b010; set_ops(32'd4, 32'd4); apply_d(d); step("f3_010");
      chk("f3_010.PCSrcE", 64'(bus.PCSrcE), 64'd0);

      // Target wrap and jump, then bubble
      d = zero_st; d.valid = 1; d.jump = 1; d.pc = 32'hFFFF_FFFC; d.imm = 32'h8;
      apply_d(d); step("jal_wrap");
      chk("jal_wrap.target", 64'(bus.PCTargetE), 64'h4);
      chk("jal_wrap.PCSrcE", 64'(bus.PCSrcE), 64'd1);
      bus.FlushE = 1'b1; step("jal_flush");
      chk("jal_flush.PCSrcE", 64'(bus.PCSrcE), 64'd0);

      // Counters: 3 bubbles then 2 taken jumps
      do_reset();
      for (int i = 0; i < 3; i++) step("cnt_flush");
      bus.FlushE = 1'b0;
      for (int i = 0; i < 3; i++) step("cnt_jump");
`ifdef ID_EX_PERF_CNT_EN
      chk("cnt.BubbleCnt", 64'(bus.BubbleCnt), 64'd3);
      chk("cnt.TakenCnt",  64'(bus.TakenCnt),  64'd2);
`else
      chk("cnt.BubbleCnt", 64'(bus.BubbleCnt), 64'd0);
      chk("cnt.TakenCnt",  64'(bus.TakenCnt),  64'd0);
`endif

      // Asynchronous reset between edges
      d = zero_st; d.valid = 1; d.rw = 1; d.rd = 5; apply_d(d); step("pre_arst");
      chk("pre_arst.RdE", 64'(bus.RdE), 64'd5);
      #3;
      reset = 1'b1;
      m = zero_st; m_bub = 0; m_taken = 0;
      #1;
      check_all("arst");
      chk("arst.PCSrcE", 64'(bus.PCSrcE), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         d.valid  = 1'($urandom_range(0, 3) != 0);
         d.rw     = 1'($urandom);  d.mw = 1'($urandom);
         d.jump   = ($urandom_range(0, 7) == 0);
         d.branch = 1'($urandom);  d.alusrc = 1'($urandom);
         d.rsrc   = 2'($urandom);  d.aluc = 3'($urandom); d.f3 = 3'($urandom);
         d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom;
         d.pc  = $urandom; d.pc4 = $urandom;
         d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
         apply_d(d);
         bus.StallE = ($urandom_range(0, 5) == 0);
         bus.FlushE = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            op_a = $urandom;
            set_ops(op_a, op_a);
         end else begin
            set_ops($urandom, $urandom);
         end
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
